// File: rtl/data_ram_pkg.sv
// Shared constants and state encoding for the data-side memory (data_ram).
package data_ram_pkg;
  localparam int DATA_ADDR_W       = 32;
  localparam int DATA_W            = 32;
  localparam int DATA_MEM_NUM_LOG2 = 10;

  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic RST_ENABLE    = 1'b1;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    DRAM_IDLE = 2'b00,
    DRAM_WAIT = 2'b01,
    DRAM_ACK  = 2'b10
  } dram_state_e;
endpackage

// File: rtl/data_ram_lane.sv
// One byte lane of the data memory: 8-bit x 2^DEPTH_LOG2 bank, write on clk, async read.
module data_ram_lane #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);
  logic [7:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];
endmodule

// File: rtl/data_ram.sv
// Data memory on the mem-stage bus: latches a request, optionally waits, then commits/reads and acks.
// Define DATA_RAM_WAIT_EN to compile in the WAIT state and WAIT_CYCLES wait states.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int DEPTH_LOG2  = DATA_MEM_NUM_LOG2,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce_i,
  input  logic                   we_i,
  input  logic [DATA_ADDR_W-1:0] addr_i,
  input  logic [3:0]             sel_i,
  input  logic [DATA_W-1:0]      data_i,
  output logic [DATA_W-1:0]      data_o,
  output logic                   ack_o,
  output logic                   stallreq_o
);
  dram_state_e           state;
  logic                  we;
  logic [DEPTH_LOG2-1:0] idx;
  logic [3:0]            sel;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;
  logic                  commit;
  logic                  unused_addr;

  assign unused_addr = ^{addr_i[DATA_ADDR_W-1:DEPTH_LOG2+2], addr_i[1:0]};

`ifdef DATA_RAM_WAIT_EN
  localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

  logic [3:0]            cnt;
  logic                  we_p0;
  logic [DEPTH_LOG2-1:0] idx_p0;
  logic [3:0]            sel_p0;
  logic [DATA_W-1:0]     data_p0;

  // Commit happens on the edge entering ACK: straight from IDLE or on the last WAIT cycle.
  always_comb begin
    we     = we_i;
    idx    = addr_i[DEPTH_LOG2+1:2];
    sel    = sel_i;
    wdata  = data_i;
    commit = 1'b0;
    if (state == DRAM_WAIT) begin
      we    = we_p0;
      idx   = idx_p0;
      sel   = sel_p0;
      wdata = data_p0;
    end
    if (rst != RST_ENABLE && ce_i == CHIP_ENABLE)
      commit = (state == DRAM_IDLE && WAIT_N == 4'd0) ||
               (state == DRAM_WAIT && cnt == 4'd1);
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= DRAM_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        DRAM_IDLE: begin
          if (ce_i == CHIP_ENABLE) begin
            we_p0   <= we_i;
            idx_p0  <= addr_i[DEPTH_LOG2+1:2];
            sel_p0  <= sel_i;
            data_p0 <= data_i;
            if (WAIT_N == 4'd0) begin
              state <= DRAM_ACK;
            end else begin
              cnt   <= WAIT_N;
              state <= DRAM_WAIT;
            end
          end
        end
        DRAM_WAIT: begin
          if (ce_i == CHIP_DISABLE) begin
            state <= DRAM_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= DRAM_ACK;
          end
        end
        DRAM_ACK: state <= DRAM_IDLE;
        default:  state <= DRAM_IDLE;
      endcase
    end
  end
`else
  localparam int UNUSED_WAIT_CYCLES = WAIT_CYCLES;

  always_comb begin
    we     = we_i;
    idx    = addr_i[DEPTH_LOG2+1:2];
    sel    = sel_i;
    wdata  = data_i;
    commit = (rst != RST_ENABLE) && (ce_i == CHIP_ENABLE) && (state == DRAM_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= DRAM_IDLE;
    end else begin
      case (state)
        DRAM_IDLE: if (ce_i == CHIP_ENABLE) state <= DRAM_ACK;
        DRAM_ACK:  state <= DRAM_IDLE;
        default:   state <= DRAM_IDLE;
      endcase
    end
  end
`endif

  for (genvar i = 0; i < 4; i++) begin : g_lane
    data_ram_lane #(.DEPTH_LOG2(DEPTH_LOG2)) u_lane (
      .clk   (clk),
      .we    (commit && we == WRITE_ENABLE && sel[i]),
      .idx   (idx),
      .wdata (wdata[8*i +: 8]),
      .rdata (rdata[8*i +: 8])
    );
  end

  // Output stage: ack and load data registered on the commit edge.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      ack_o  <= 1'b0;
      data_o <= ZERO_WORD;
    end else begin
      ack_o  <= commit;
      data_o <= (commit && we == WRITE_DISABLE) ? rdata : ZERO_WORD;
    end
  end

  assign stallreq_o = ce_i & ~ack_o;
endmodule

// File: tb/tb_data_ram.sv
// Scoreboard bench for data_ram: expected load data queued at request, checked on every ack.
module tb_data_ram;
`ifdef DATA_RAM_WAIT_EN
  localparam int WAIT_EFF = 3;
`else
  localparam int WAIT_EFF = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        stallreq_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  data_ram #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .sel_i      (sel_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .ack_o      (ack_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every cycle: an ack pops one expected word, otherwise data_o must be zero.
  always @(posedge clk) begin
    #1;
    if (ack_o) begin
      if (exp_q.size() == 0) check("spurious_ack", 32'd1, 32'd0);
      else check("rdata", data_o, exp_q.pop_front());
    end else begin
      check("data_idle", data_o, 32'd0);
    end
  end

  task automatic wait_ack(output int cyc, output logic got);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      if (ack_o) got = 1'b1;
      else begin
        check("stall_wait", {31'd0, stallreq_o}, 32'd1);
        cyc++;
      end
    end
    check("ack_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d);
    ce_i = 1'b1; we_i = w; addr_i = a; sel_i = s; data_i = d;
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] exp);
    int   cyc;
    logic got;
    @(negedge clk);
    drive(w, a, s, d);
    exp_q.push_back(w ? 32'd0 : exp);
    #1 check("stall_first", {31'd0, stallreq_o}, 32'd1);
    wait_ack(cyc, got);
    check("latency", 32'(cyc), 32'(WAIT_EFF));
    check("stall_ack", {31'd0, stallreq_o}, 32'd0);
    @(negedge clk);
    ce_i = 1'b0;
  endtask

  initial begin
    int   cyc;
    logic got;
    rst = 1'b1; ce_i = 1'b0; we_i = 1'b0; addr_i = '0; sel_i = '0; data_i = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", {31'd0, ack_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_stall_lo", {31'd0, stallreq_o}, 32'd0);
    ce_i = 1'b1;
    #1 check("rst_stall_hi", {31'd0, stallreq_o}, 32'd1);
    @(negedge clk);
    ce_i = 1'b0;
    rst = 1'b0;

    do_req(1'b1, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0);
    do_req(1'b0, 32'h100, 4'b0000, 32'h0, 32'hDEADBEEF);
    do_req(1'b1, 32'h100, 4'b0100, 32'h00AA0000, 32'h0);
    do_req(1'b0, 32'h100, 4'b0001, 32'h0, 32'hDEAABEEF);
    do_req(1'b1, 32'h100, 4'b1001, 32'h12FFFF34, 32'h0);
    do_req(1'b0, 32'h100, 4'b1111, 32'h0, 32'h12AABE34);
    do_req(1'b1, 32'h100, 4'b0000, 32'hFFFFFFFF, 32'h0);
    do_req(1'b0, 32'h100, 4'b1111, 32'h0, 32'h12AABE34);
    do_req(1'b1, 32'h1000, 4'b1111, 32'hCAFEF00D, 32'h0);
    do_req(1'b0, 32'h0, 4'b1111, 32'h0, 32'hCAFEF00D);
    do_req(1'b0, 32'h3, 4'b1111, 32'h0, 32'hCAFEF00D);

    // ce_i held through the ack: the following IDLE cycle starts a second request.
    @(negedge clk);
    drive(1'b0, 32'h100, 4'b1111, 32'h0);
    exp_q.push_back(32'h12AABE34);
    exp_q.push_back(32'h12AABE34);
    wait_ack(cyc, got);
    check("b2b_lat1", 32'(cyc), 32'(WAIT_EFF));
    wait_ack(cyc, got);
    check("b2b_gap", 32'(cyc), 32'(1 + WAIT_EFF));
    @(negedge clk);
    ce_i = 1'b0;

    // A request sampled while rst is high must not write.
    do_req(1'b1, 32'h300, 4'b1111, 32'h55555555, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 32'h300, 4'b1111, 32'h66666666);
    @(posedge clk); #1;
    check("rst_req_ack", {31'd0, ack_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0; ce_i = 1'b0;
    do_req(1'b0, 32'h300, 4'b1111, 32'h0, 32'h55555555);

`ifdef DATA_RAM_WAIT_EN
    do_req(1'b1, 32'h200, 4'b1111, 32'h11111111, 32'h0);
    // Abort: ce_i dropped during WAIT.
    @(negedge clk);
    drive(1'b1, 32'h200, 4'b1111, 32'h22222222);
    @(posedge clk); #1;
    check("abort_ack0", {31'd0, ack_o}, 32'd0);
    @(negedge clk);
    ce_i = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      check("abort_noack", {31'd0, ack_o}, 32'd0);
    end
    do_req(1'b0, 32'h200, 4'b1111, 32'h0, 32'h11111111);
    // Reset while in WAIT drops the pending store.
    @(negedge clk);
    drive(1'b1, 32'h200, 4'b1111, 32'h33333333);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstwait_ack", {31'd0, ack_o}, 32'd0);
    check("rstwait_data", data_o, 32'd0);
    @(negedge clk);
    rst = 1'b0; ce_i = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("rstwait_noack", {31'd0, ack_o}, 32'd0);
    end
    do_req(1'b0, 32'h200, 4'b1111, 32'h0, 32'h11111111);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
